// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Guard-blanked slots, frame-aligned shadow load, per-digit blink.
module display_scan_ctrl #(
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD_CYC    = 4,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits_in,
   input  logic        load,
   input  logic [3:0]  blink_mask,
   output logic        load_ack,
   output logic        frame_start,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] G_LAST  = CW'(GUARD_CYC - 1);
   localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

   typedef enum logic {GUARD, DRIVE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [FW-1:0] frm_q, frm_d;
   logic          ph_q, ph_d;
   logic [15:0]   sh_q, sh_d;
   logic          ack_q, ack_d;
   logic          fs_q, fs_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          wrap, frame_end;
   logic [3:0]    nib;

   function automatic logic [6:0] bcd7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // State register for the guard/drive slot FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= GUARD;
      else        state_q <= state_d;
   end

   // Guard ends after GUARD_CYC cycles; drive ends at slot wrap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         GUARD: if (cnt_q == G_LAST) state_d = DRIVE;
         DRIVE: if (wrap)            state_d = GUARD;
         default:                    state_d = GUARD;
      endcase
   end

   // Next anode/segment values; blanked in guard, blink forces blank.
   always_comb begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      nib   = sh_q[{idx_q, 2'b00} +: 4];
      if (state_q == DRIVE) begin
         an_d = ~(4'b0001 << idx_q);
         if (!(ph_q && blink_mask[idx_q])) seg_d = bcd7(nib);
      end
   end

   // Slot/digit/frame counters and frame-aligned shadow capture.
   always_comb begin
      wrap      = (cnt_q == CNT_MAX);
      frame_end = wrap && (idx_q == 2'd3);
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      idx_d     = wrap ? idx_q + 2'd1 : idx_q;
      frm_d     = frm_q;
      ph_d      = ph_q;
      sh_d      = sh_q;
      ack_d     = 1'b0;
      fs_d      = frame_end;
      if (frame_end) begin
         if (frm_q == FRM_MAX) begin
            frm_d = '0;
            ph_d  = ~ph_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
         if (load) begin
            sh_d  = digits_in;
            ack_d = 1'b1;
         end
      end
   end

   // All datapath and output registers, synchronously reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
         frm_q <= '0;
         ph_q  <= 1'b0;
         sh_q  <= 16'h0000;
         ack_q <= 1'b0;
         fs_q  <= 1'b0;
         an_q  <= 4'hF;
         seg_q <= 7'h7F;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         frm_q <= frm_d;
         ph_q  <= ph_d;
         sh_q  <= sh_d;
         ack_q <= ack_d;
         fs_q  <= fs_d;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign load_ack    = ack_q;
   assign frame_start = fs_q;
   assign an          = an_q;
   assign seg         = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl.
// Reference model derives everything from an absolute cycle count.
module tb_display_scan_ctrl;

   localparam int D  = 8;
   localparam int G  = 2;
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  blink_mask = 4'h0;
   logic        load_ack, frame_start;
   logic [3:0]  an;
   logic [6:0]  seg;

   display_scan_ctrl #(
      .SCAN_DIV(D), .GUARD_CYC(G), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in),
      .load(load), .blink_mask(blink_mask),
      .load_ack(load_ack), .frame_start(frame_start),
      .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] an;
      logic [6:0] seg;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [6:0]  dec_tab [16];
   int          m_n = 0;
   logic [15:0] m_sh = 16'h0000;
   vec_t        tab [14];

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: predict, step, compare, advance the model.
   task automatic tick();
      int cnt, idx, fr;
      logic ph, bnd;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_ack, e_fs, ld;
      logic [15:0] din;
      ld  = load;
      din = digits_in;
      bnd = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_ack = 1'b0; e_fs = 1'b0;
      if (rst_n) begin
         cnt = m_n % D;
         idx = (m_n / D) % 4;
         fr  = m_n / (4 * D);
         ph  = ((fr / BF) % 2) == 1;
         bnd = (cnt == D - 1) && (idx == 3);
         e_fs  = bnd;
         e_ack = bnd && ld;
         if (cnt >= G) begin
            e_an[idx] = 1'b0;
            if (!(ph && blink_mask[idx])) e_seg = dec_tab[m_sh[idx*4 +: 4]];
         end
      end
      @(posedge clk);
      #1;
      chk("an", {12'h0, an}, {12'h0, e_an});
      chk("seg", {9'h0, seg}, {9'h0, e_seg});
      chk("load_ack", {15'h0, load_ack}, {15'h0, e_ack});
      chk("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
      if (!rst_n) begin
         m_n = 0;
         m_sh = 16'h0000;
      end else begin
         if (bnd && ld) m_sh = din;
         m_n++;
      end
   endtask

   task automatic wait_fs(input string nm);
      int k;
      k = 0;
      while (k < 4 * D + 2) begin
         tick();
         k++;
         if (frame_start === 1'b1) break;
      end
      chk({nm, "_fs_seen"}, {15'h0, frame_start}, 16'h0001);
   endtask

   // Scan one full frame, checking each digit's segments in drive.
   task automatic scan_frame(input string nm, input logic [27:0] exp);
      int seen;
      seen = 0;
      for (int i = 0; i < 4 * D; i++) begin
         tick();
         for (int d = 0; d < 4; d++) begin
            if (an == ~(4'b0001 << d)) begin
               seen++;
               chk($sformatf("%s_d%0d", nm, d), {9'h0, seg},
                   {9'h0, exp[d*7 +: 7]});
            end
         end
      end
      chk({nm, "_drive_cnt"}, 16'(seen), 16'(4 * (D - G)));
   endtask

   initial begin
      int acks;
      dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
      dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
      dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
      dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
      dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
      for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;

      for (int i = 0; i < 3; i++) tab[i] = '{1'b0, 4'hF, 7'h7F};
      tab[3] = '{1'b1, 4'hF, 7'h7F};
      tab[4] = '{1'b1, 4'hF, 7'h7F};
      for (int i = 5; i < 11; i++) tab[i] = '{1'b1, 4'hE, 7'h40};
      tab[11] = '{1'b1, 4'hF, 7'h7F};
      tab[12] = '{1'b1, 4'hF, 7'h7F};
      tab[13] = '{1'b1, 4'hD, 7'h40};

      // Reset and first slots from fixed vectors.
      for (int i = 0; i < 14; i++) begin
         rst_n = tab[i].rst;
         tick();
         chk($sformatf("vec%0d_an", i), {12'h0, an}, {12'h0, tab[i].an});
         chk($sformatf("vec%0d_seg", i), {9'h0, seg}, {9'h0, tab[i].seg});
      end

      // Held load of 1234 captured at the first boundary.
      load = 1'b1;
      digits_in = 16'h1234;
      wait_fs("load1234");
      chk("load1234_ack", {15'h0, load_ack}, 16'h0001);
      scan_frame("f1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
      load = 1'b0;

      // Load withdrawn mid-frame: no capture, no ack.
      load = 1'b1;
      digits_in = 16'h5678;
      for (int i = 0; i < 10; i++) tick();
      load = 1'b0;
      acks = 0;
      for (int i = 0; i < 4 * D - 10; i++) begin
         tick();
         if (load_ack === 1'b1) acks++;
      end
      chk("withdrawn_fs", {15'h0, frame_start}, 16'h0001);
      chk("withdrawn_acks", 16'(acks), 16'h0000);
      scan_frame("fkeep", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

      // Digit 9 and out-of-range dash.
      load = 1'b1;
      digits_in = 16'h00A9;
      wait_fs("load00A9");
      load = 1'b0;
      scan_frame("f00A9", {7'b1000000, 7'b1000000, 7'b0111111, 7'b0010000});

      // Blink digit0 over several frames.
      blink_mask = 4'b0001;
      for (int i = 0; i < 8 * 4 * D; i++) tick();

      // Reset pulse mid-drive with load pending.
      acks = 0;
      while (an !== 4'hD && acks < 4 * D) begin
         tick();
         acks++;
      end
      tick();
      tick();
      load = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("rst_mid_an", {12'h0, an}, 16'h000F);
      chk("rst_mid_seg", {9'h0, seg}, 16'h007F);
      rst_n = 1'b1;
      for (int i = 1; i <= 4 * D; i++) begin
         tick();
         chk($sformatf("rst_ack%0d", i), {15'h0, load_ack},
             {15'h0, (i == 4 * D)});
      end
      load = 1'b0;
      blink_mask = 4'h0;

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) load = ~load;
         if ($urandom_range(0, 7) == 0) digits_in = 16'($urandom);
         if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
      end
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (≥4).
REQ-002 Parameter GUARD_CYC, default 4, anti-ghosting blank cycles at the start of each slot (1 ≤ GUARD_CYC < SCAN_DIV).
REQ-003 Parameter BLINK_FRAMES, default 125, frames per blink half-period (≥1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 digits_in  input  16  four BCD nibbles; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-007 load  input  1  level update request; held until load_ack or withdrawn.
REQ-008 blink_mask  input  4  bit i set = digit i blinks.
REQ-009 load_ack  output  1  one-cycle pulse: digits_in captured.
REQ-010 frame_start  output  1  one-cycle pulse at each frame boundary.
REQ-011 an  output  4  anode enables, active-low, registered.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.

Function
REQ-013 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index idx (2 bits) SHALL advance 0→1→2→3→0 on the edge where cnt wraps.
REQ-014 Per slot, FSM SHALL be in GUARD while cnt < GUARD_CYC and DRIVE otherwise; GUARD→DRIVE at cnt = GUARD_CYC, DRIVE→GUARD at the wrap.
REQ-015 GUARD: an = 4'b1111, seg = 7'h7F; DRIVE: an has only bit idx low, seg = decode of shadow digit idx.
REQ-016 an/seg SHALL be registered, reflecting the cnt/idx/state values held before the same edge (one-cycle latency).
REQ-017 Decode: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000; 10–15 → dash 0111111.
REQ-018 Frame boundary = edge where idx wraps 3→0; frame_start high for exactly the following cycle.
REQ-019 If load = 1 at a frame boundary edge, the 16-bit shadow register SHALL capture digits_in at that edge and load_ack SHALL be high for the following cycle only.
REQ-020 Display content SHALL change only at frame boundaries (no tearing within a frame).
REQ-021 load withdrawn before a boundary: no capture, no ack; load held after ack: recaptured at the next boundary (new ack).
REQ-022 Frame counter SHALL count frames 0..BLINK_FRAMES-1 and toggle blink_phase on wrap; blink_phase = 1 forces seg = 7'h7F during DRIVE for digits with blink_mask bit set (an still driven).
REQ-023 blink_mask SHALL be sampled every cycle (no frame alignment).

Reset
REQ-024 rst_n = 0 at an edge SHALL set: cnt = 0, idx = 0, state GUARD, shadow = 16'h0000, frame counter = 0, blink_phase = 0, an = 4'hF, seg = 7'h7F, load_ack = 0, frame_start = 0.
REQ-025 Reset mid-slot or mid-request SHALL take effect on that edge; no pending load persists; first frame after release starts at idx 0 in GUARD.
REQ-026 With shadow = 0 after reset, all four digits show "0" until the first capture.

Verification (SCAN_DIV=8, GUARD_CYC=2, BLINK_FRAMES=2)
REQ-027 rst_n low 3 cycles, then high → an = F/seg = 7F during reset; afterwards per slot 2 cycles an=1111 then 6 cycles an=1110, 1101, 1011, 0111 in turn, seg = 1000000.
REQ-028 load = 1, digits_in = 16'h1234 held → load_ack/frame_start pulse together after the first 3→0 wrap; next frame digit0 seg = 0011001, digit3 seg = 1111001.
REQ-029 load raised then dropped mid-frame → no load_ack, display unchanged.
REQ-030 digits_in = 16'h00A9 captured → digit0 = 0010000, digit1 = 0111111 (dash).
REQ-031 blink_mask = 4'b0001 → digit0 seg = 7F during DRIVE in frames 2–3, 6–7, …; other digits unaffected.
REQ-032 rst_n low for 1 cycle mid-DRIVE with load high → an = F, seg = 7F next cycle, shadow = 0, no ack until the next boundary after release.
